mem_stage: RTL

- Memory-access stage of the 5-stage pipeline, directly downstream of the EX/MEM pipeline register.
- Uses the registered ALU result as the data address and the forwarded rs2 value as store data.
- Performs byte/half/word loads and stores over a req/gnt/rvalid data-memory bus, stalling the pipeline while the bus is busy.
- Presents registered writeback data, destination register and a misalignment flag to the MEM/WB side.

---
 rtl/mem_pkg.sv | 38 +++
 rtl/mem_stage_if.sv | 23 ++
 rtl/mem_load_align.sv | 25 ++
 rtl/mem_stage.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and constants for the memory-access pipeline stage.
package mem_pkg;

  typedef enum logic [1:0] {
    OP_NONE  = 2'b00,
    OP_LOAD  = 2'b01,
    OP_STORE = 2'b10,
    OP_RSVD  = 2'b11
  } mem_op_e;

  typedef enum logic [1:0] {
    SZ_BYTE    = 2'b00,
    SZ_HALF    = 2'b01,
    SZ_WORD    = 2'b10,
    SZ_ILLEGAL = 2'b11
  } mem_size_e;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    REQ    = 2'b01,
    WAIT_R = 2'b10
  } mem_state_e;

  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

  // The illegal size code is reported as a misalignment fault.
  function automatic logic is_aligned(input mem_size_e size, input logic [1:0] offset);
    case (size)
      SZ_BYTE: is_aligned = 1'b1;
      SZ_HALF: is_aligned = ~offset[0];
      SZ_WORD: is_aligned = (offset == 2'b00);
      default: is_aligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory bus: req/gnt request phase, rvalid/rdata read-return phase.
interface mem_stage_if #(
  parameter int WordSize = 32
);
  logic                req;
  logic                we;
  logic [WordSize-1:0] addr;
  logic [3:0]          be;
  logic [WordSize-1:0] wdata;
  logic                gnt;
  logic                rvalid;
  logic [WordSize-1:0] rdata;

  modport master (
    output req, we, addr, be, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, be, wdata,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/mem_load_align.sv
// Selects the addressed byte/half/word from a read word and extends it to 32 bits.
module mem_load_align
  import mem_pkg::*;
#(
  parameter int WordSize = 32
) (
  input  logic [WordSize-1:0] rdata,
  input  logic [1:0]          addr,
  input  mem_size_e           size,
  input  logic                load_unsigned,
  output logic [WordSize-1:0] data
);

  logic [WordSize-1:0] shifted;

  always_comb begin
    shifted = rdata >> {addr, 3'b000};
    case (size)
      SZ_BYTE: data = {{24{shifted[7] & ~load_unsigned}}, shifted[7:0]};
      SZ_HALF: data = {{16{shifted[15] & ~load_unsigned}}, shifted[15:0]};
      default: data = shifted;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: issues loads/stores on the data bus, stalls
// upstream while the bus is busy and registers the MEM/WB result.
module mem_stage
  import mem_pkg::*;
#(
  parameter int WordSize = 32
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic [4:0]          rdn_in,
  input  logic [WordSize-1:0] alu_out,
  input  logic [WordSize-1:0] mem_data,
  input  logic [1:0]          mem_op,
  input  logic [1:0]          mem_size,
  input  logic                mem_unsigned,
  output logic                stall,
  mem_stage_if.master         dmem,
  output logic [4:0]          rdn,
  output logic [WordSize-1:0] wb_data,
  output logic                misalign
);

  mem_op_e    op;
  mem_size_e  size;
  mem_state_e state, state_nxt;

  logic                is_mem;
  logic                is_store;
  logic                aligned;
  logic                req_c;
  logic                stall_c;
  logic [4:0]          rdn_nxt;
  logic [WordSize-1:0] wb_nxt;
  logic                mis_nxt;
  logic [WordSize-1:0] load_data;

  assign op       = mem_op_e'(mem_op);
  assign size     = mem_size_e'(mem_size);
  assign is_store = (op == OP_STORE);
  assign is_mem   = (op == OP_LOAD) || is_store;
  assign aligned  = is_aligned(size, alu_out[1:0]);

  mem_load_align #(
    .WordSize(WordSize)
  ) u_load_align (
    .rdata        (dmem.rdata),
    .addr         (alu_out[1:0]),
    .size         (size),
    .load_unsigned(mem_unsigned),
    .data         (load_data)
  );

  // Inputs are held stable while stalled, so REQ re-evaluates the same op as IDLE.
  always_comb begin
    // NOTE: every output gets a default before the case so no path can infer a latch.
    state_nxt = state;
    req_c     = 1'b0;
    stall_c   = 1'b0;
    rdn_nxt   = rdn_in;
    wb_nxt    = alu_out;
    mis_nxt   = 1'b0;

    case (state)
      IDLE, REQ: begin
        state_nxt = IDLE;
        if (is_mem && !aligned) begin
          rdn_nxt = '0;
          wb_nxt  = '0;
          mis_nxt = 1'b1;
        end else if (is_mem) begin
          req_c = 1'b1;
          if (!dmem.gnt) begin
            state_nxt = REQ;
            stall_c   = 1'b1;
          end else if (is_store) begin
            rdn_nxt = '0;
            wb_nxt  = '0;
          end else begin
            state_nxt = WAIT_R;
            stall_c   = 1'b1;
          end
        end
      end
      WAIT_R: begin
        if (dmem.rvalid) begin
          state_nxt = IDLE;
          wb_nxt    = load_data;
        end else begin
          stall_c = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase

    // A stalled cycle hands a bubble to MEM/WB.
    if (stall_c) begin
      rdn_nxt = '0;
      wb_nxt  = '0;
      mis_nxt = 1'b0;
    end
  end

  assign stall    = stall_c & rstn;
  assign dmem.req = req_c & rstn;
  assign dmem.we  = is_store;
  assign dmem.addr = {alu_out[WordSize-1:2], 2'b00};

  always_comb begin
    case (size)
      SZ_BYTE: begin
        dmem.wdata = {4{mem_data[7:0]}};
        dmem.be    = BE_BYTE << alu_out[1:0];
      end
      SZ_HALF: begin
        dmem.wdata = {2{mem_data[15:0]}};
        dmem.be    = alu_out[1] ? {BE_HALF[1:0], 2'b00} : BE_HALF;
      end
      default: begin
        dmem.wdata = mem_data;
        dmem.be    = BE_WORD;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      rdn      <= '0;
      wb_data  <= '0;
      misalign <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      state    <= state_nxt;
      rdn      <= rdn_nxt;
      wb_data  <= wb_nxt;
      misalign <= mis_nxt;
    end
  end

endmodule
